// File: rtl/exc_ctrl.sv
// exc_ctrl: exception sequencing unit in front of CP0 for the multicycle core.
// Ports: clk, rst (async high); instr_valid, is_syscall/break/teq/eret, teq_eq,
//   pc_in[31:0], status[31:0], ext_int -> exception, eret, cause[4:0],
//   exc_pc[31:0], pc_redirect, busy, int_pending.
module exc_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic        is_teq,
  input  logic        is_eret,
  input  logic        teq_eq,
  input  logic [31:0] pc_in,
  input  logic [31:0] status,
  input  logic        ext_int,
  output logic        exception,
  output logic        eret,
  output logic [4:0]  cause,
  output logic [31:0] exc_pc,
  output logic        pc_redirect,
  output logic        busy,
  output logic        int_pending
);

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    ERET,
    REDIRECT
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   int_rise;

  logic       idle_v;
  logic       take_eret;
  logic       take_sys;
  logic       take_brk;
  logic       take_teq;
  logic       take_int;
  logic       take_trap;
  logic [4:0] cause_n;
  logic [31:0] pc_n;

  // ext_int is asynchronous; only the last stage is used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], ext_int};
      sync_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign int_rise = sync[SYNC_STAGES-1] & ~sync_prev;

  assign idle_v    = (state == IDLE) & instr_valid;
  assign take_eret = idle_v & is_eret;
  assign take_sys  = idle_v & is_syscall & status[0] & status[1];
  assign take_brk  = idle_v & is_break & status[0] & status[2];
  assign take_teq  = idle_v & is_teq & teq_eq & status[0] & status[3];

  // A disabled decode flag retires as a NOP, so a pending interrupt
  // can still ride on that commit.
  assign take_int  = idle_v & ~is_eret & ~take_sys & ~take_brk & ~take_teq
                   & int_pending & status[0] & status[4];

  assign take_trap = ~is_eret & (take_sys | take_brk | take_teq | take_int);

  always_comb begin
    cause_n = 5'd0;
    pc_n    = pc_in;
    if (take_sys) begin
      cause_n = 5'd8;
    end else if (take_brk) begin
      cause_n = 5'd9;
    end else if (take_teq) begin
      cause_n = 5'd13;
    end else begin
      cause_n = 5'd0;
      pc_n    = pc_in + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cause       <= 5'd0;
      exc_pc      <= 32'd0;
      int_pending <= 1'b0;
    end else begin
      state <= state_n;
      if (take_trap) begin
        cause  <= cause_n;
        exc_pc <= pc_n;
      end
      // A new edge in the clear cycle wins over the clear.
      if (int_rise) begin
        int_pending <= 1'b1;
      end else if (take_int) begin
        int_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n     = state;
    exception   = 1'b0;
    eret        = 1'b0;
    pc_redirect = 1'b0;
    busy        = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_eret) begin
          state_n = ERET;
        end else if (take_trap) begin
          state_n = TRAP;
        end
      end
      TRAP: begin
        exception = 1'b1;
        busy      = 1'b1;
        state_n   = REDIRECT;
      end
      ERET: begin
        eret    = 1'b1;
        busy    = 1'b1;
        state_n = REDIRECT;
      end
      REDIRECT: begin
        pc_redirect = 1'b1;
        busy        = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed self-checking bench for exc_ctrl.
// Drives vectors just after posedge and checks outputs 1ns after posedge.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        is_syscall;
  logic        is_break;
  logic        is_teq;
  logic        is_eret;
  logic        teq_eq;
  logic [31:0] pc_in;
  logic [31:0] status;
  logic        ext_int;
  logic        exception;
  logic        eret;
  logic [4:0]  cause;
  logic [31:0] exc_pc;
  logic        pc_redirect;
  logic        busy;
  logic        int_pending;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .is_syscall  (is_syscall),
    .is_break    (is_break),
    .is_teq      (is_teq),
    .is_eret     (is_eret),
    .teq_eq      (teq_eq),
    .pc_in       (pc_in),
    .status      (status),
    .ext_int     (ext_int),
    .exception   (exception),
    .eret        (eret),
    .cause       (cause),
    .exc_pc      (exc_pc),
    .pc_redirect (pc_redirect),
    .busy        (busy),
    .int_pending (int_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    instr_valid = 1'b0;
    is_syscall  = 1'b0;
    is_break    = 1'b0;
    is_teq      = 1'b0;
    is_eret     = 1'b0;
    teq_eq      = 1'b0;
  endtask

  task automatic commit(input logic [31:0] st, input logic [31:0] pc,
                        input logic sy, input logic bk, input logic tq,
                        input logic eq, input logic er);
    status      = st;
    pc_in       = pc;
    is_syscall  = sy;
    is_break    = bk;
    is_teq      = tq;
    teq_eq      = eq;
    is_eret     = er;
    instr_valid = 1'b1;
    step();
    clr();
  endtask

  initial begin
    rst     = 1'b1;
    ext_int = 1'b0;
    status  = 32'h0;
    pc_in   = 32'h0;
    clr();
    step();
    step();
    chk("rst_exc", {31'd0, exception}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cause", {27'd0, cause}, 32'd0);
    chk("rst_pc", exc_pc, 32'd0);
    rst = 1'b0;
    step();

    // syscall enabled
    commit(32'h3, 32'h0040_0010, 1, 0, 0, 0, 0);
    chk("sys_exc", {31'd0, exception}, 32'd1);
    chk("sys_cause", {27'd0, cause}, 32'd8);
    chk("sys_pc", exc_pc, 32'h0040_0010);
    chk("sys_busy1", {31'd0, busy}, 32'd1);
    chk("sys_redir1", {31'd0, pc_redirect}, 32'd0);
    step();
    chk("sys_redir", {31'd0, pc_redirect}, 32'd1);
    chk("sys_exc2", {31'd0, exception}, 32'd0);
    chk("sys_busy2", {31'd0, busy}, 32'd1);
    step();
    chk("sys_busy3", {31'd0, busy}, 32'd0);
    chk("sys_redir3", {31'd0, pc_redirect}, 32'd0);

    // teq not equal, then equal
    commit(32'h9, 32'h0040_0100, 0, 0, 1, 0, 0);
    chk("teq0_exc", {31'd0, exception}, 32'd0);
    chk("teq0_busy", {31'd0, busy}, 32'd0);
    commit(32'h9, 32'h0040_0104, 0, 0, 1, 1, 0);
    chk("teq1_exc", {31'd0, exception}, 32'd1);
    chk("teq1_cause", {27'd0, cause}, 32'd13);
    chk("teq1_pc", exc_pc, 32'h0040_0104);
    step();
    step();

    // break enabled
    commit(32'h5, 32'h0040_0200, 0, 1, 0, 0, 0);
    chk("brk_cause", {27'd0, cause}, 32'd9);
    step();
    step();

    // syscall disabled: NOP, latched values held
    commit(32'h1, 32'h0040_0300, 1, 0, 0, 0, 0);
    chk("sysdis_exc", {31'd0, exception}, 32'd0);
    chk("sysdis_busy", {31'd0, busy}, 32'd0);
    chk("sysdis_cause", {27'd0, cause}, 32'd9);
    chk("sysdis_pc", exc_pc, 32'h0040_0200);

    // interrupt latency and take
    ext_int = 1'b1;
    step();
    chk("int_lat1", {31'd0, int_pending}, 32'd0);
    step();
    chk("int_lat2", {31'd0, int_pending}, 32'd0);
    step();
    chk("int_lat3", {31'd0, int_pending}, 32'd1);
    ext_int = 1'b0;
    step();
    commit(32'h11, 32'h0040_0020, 0, 0, 0, 0, 0);
    chk("int_exc", {31'd0, exception}, 32'd1);
    chk("int_cause", {27'd0, cause}, 32'd0);
    chk("int_pc", exc_pc, 32'h0040_0024);
    chk("int_clr", {31'd0, int_pending}, 32'd0);
    step();
    step();

    // trap and pending interrupt together, then interrupt with pc wrap
    ext_int = 1'b1;
    step();
    step();
    step();
    ext_int = 1'b0;
    chk("int2_pend", {31'd0, int_pending}, 32'd1);
    commit(32'h13, 32'h0040_0400, 1, 0, 0, 0, 0);
    chk("both_cause", {27'd0, cause}, 32'd8);
    chk("both_pend", {31'd0, int_pending}, 32'd1);
    step();
    step();
    commit(32'h11, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    chk("wrap_cause", {27'd0, cause}, 32'd0);
    chk("wrap_pc", exc_pc, 32'h0);
    chk("wrap_clr", {31'd0, int_pending}, 32'd0);
    step();
    step();

    // eret ignores status
    commit(32'h0, 32'h0040_0500, 0, 0, 0, 0, 1);
    chk("eret_p", {31'd0, eret}, 32'd1);
    chk("eret_exc", {31'd0, exception}, 32'd0);
    chk("eret_busy", {31'd0, busy}, 32'd1);
    step();
    chk("eret_redir", {31'd0, pc_redirect}, 32'd1);
    chk("eret_p2", {31'd0, eret}, 32'd0);
    step();
    chk("eret_idle", {31'd0, busy}, 32'd0);

    // reset during TRAP
    commit(32'h3, 32'h0040_0600, 1, 0, 0, 0, 0);
    chk("rtrap_exc", {31'd0, exception}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rtrap_exc0", {31'd0, exception}, 32'd0);
    chk("rtrap_busy", {31'd0, busy}, 32'd0);
    chk("rtrap_cause", {27'd0, cause}, 32'd0);
    chk("rtrap_pc", exc_pc, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rtrap_redir", {31'd0, pc_redirect}, 32'd0);
    step();
    chk("rtrap_redir2", {31'd0, pc_redirect}, 32'd0);
    chk("rtrap_busy2", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
